// File: rtl/dart_sensor_scanner.sv
// Dart target front-end: scans the 10x10 sense matrix, debounces hits,
// strobes the hit cell to the scoring FSM and locks out until turn end.
module dart_sensor_scanner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] row_sel_o,
   input  logic [9:0] col_sense_i,
   input  logic       turn_done_i,
   input  logic       game_set_i,
   output logic       dart_come_o,
   output logic [3:0] dart_position_x_o,
   output logic [3:0] dart_position_y_o,
   output logic       busy_o,
   output logic       error_o
);

   typedef enum logic [2:0] {
      SCAN,
      CONFIRM,
      EMIT,
      WAIT_ACK,
      WAIT_CLEAR,
      HALT
   } state_t;

   localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);

   state_t     state, state_n;
   logic [3:0] row_idx, row_idx_n;
   logic [3:0] cap_x, cap_x_n;
   logic [3:0] pos_x, pos_x_n;
   logic [3:0] pos_y, pos_y_n;
   logic [7:0] cnt, cnt_n;
   logic       err, err_n;

   logic [7:0] cnt_inc;
   logic [3:0] row_inc;
   logic [3:0] col_enc;
   logic       col_zero;
   logic       col_one;
   logic       col_match;

   function automatic logic [3:0] enc10(input logic [9:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

   assign cnt_inc   = cnt + 8'd1;
   assign row_inc   = (row_idx == 4'd9) ? 4'd0 : row_idx + 4'd1;
   assign col_enc   = enc10(col_sense_i);
   assign col_zero  = (col_sense_i == 10'd0);
   assign col_one   = !col_zero &&
                      ((col_sense_i & (col_sense_i - 10'd1)) == 10'd0);
   assign col_match = (col_sense_i == (10'd1 << cap_x));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= SCAN;
         row_idx <= 4'd0;
         cap_x   <= 4'd0;
         pos_x   <= 4'd0;
         pos_y   <= 4'd0;
         cnt     <= 8'd0;
         err     <= 1'b0;
      end else begin
         state   <= state_n;
         row_idx <= row_idx_n;
         cap_x   <= cap_x_n;
         pos_x   <= pos_x_n;
         pos_y   <= pos_y_n;
         cnt     <= cnt_n;
         err     <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      row_idx_n = row_idx;
      cap_x_n   = cap_x;
      pos_x_n   = pos_x;
      pos_y_n   = pos_y;
      cnt_n     = cnt;
      err_n     = 1'b0;
      if (game_set_i) begin
         state_n = HALT;
      end else begin
         unique case (state)
            SCAN: begin
               unique case (1'b1)
                  col_zero: row_idx_n = row_inc;
                  col_one: begin
                     cap_x_n = col_enc;
                     cnt_n   = 8'd1;
                     if (DEB == 8'd1) begin
                        state_n = EMIT;
                        pos_x_n = col_enc;
                        pos_y_n = row_idx;
                     end else begin
                        state_n = CONFIRM;
                     end
                  end
                  default: begin
                     err_n     = 1'b1;
                     row_idx_n = row_inc;
                  end
               endcase
            end
            CONFIRM: begin
               if (col_match) begin
                  cnt_n = cnt_inc;
                  if (cnt_inc >= DEB) begin
                     state_n = EMIT;
                     pos_x_n = cap_x;
                     pos_y_n = row_idx;
                  end
               end else begin
                  state_n   = SCAN;
                  row_idx_n = row_inc;
               end
            end
            EMIT: state_n = WAIT_ACK;
            WAIT_ACK: begin
               if (turn_done_i) begin
                  state_n = WAIT_CLEAR;
                  cnt_n   = 8'd0;
               end
            end
            WAIT_CLEAR: begin
               if (!col_zero) begin
                  cnt_n = 8'd0;
               end else if (cnt_inc >= DEB) begin
                  state_n   = SCAN;
                  row_idx_n = 4'd0;
                  cnt_n     = 8'd0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            HALT: state_n = HALT;
            default: state_n = SCAN;
         endcase
      end
   end

   always_comb begin
      row_sel_o = 10'd0;
      unique case (state)
         SCAN, CONFIRM: row_sel_o = 10'd1 << row_idx;
         WAIT_CLEAR:    row_sel_o = 10'h3FF;
         default:       row_sel_o = 10'd0;
      endcase
   end

   assign dart_come_o       = (state == EMIT);
   assign busy_o            = (state != SCAN) && (state != CONFIRM);
   assign error_o           = err;
   assign dart_position_x_o = pos_x;
   assign dart_position_y_o = pos_y;

endmodule

// File: tb/tb_dart_sensor_scanner.sv
// Directed bench for dart_sensor_scanner (DEBOUNCE_CYCLES = 4).
module tb_dart_sensor_scanner;

   logic       clk;
   logic       reset;
   logic [9:0] row_sel_o;
   logic [9:0] col_sense_i;
   logic       turn_done_i;
   logic       game_set_i;
   logic       dart_come_o;
   logic [3:0] dart_position_x_o;
   logic [3:0] dart_position_y_o;
   logic       busy_o;
   logic       error_o;

   int checks;
   int failures;

   dart_sensor_scanner #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk),
      .reset(reset),
      .row_sel_o(row_sel_o),
      .col_sense_i(col_sense_i),
      .turn_done_i(turn_done_i),
      .game_set_i(game_set_i),
      .dart_come_o(dart_come_o),
      .dart_position_x_o(dart_position_x_o),
      .dart_position_y_o(dart_position_y_o),
      .busy_o(busy_o),
      .error_o(error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [9:0] row,
                          input logic dc, input logic bz,
                          input logic er);
      chk({tag, ".row"}, 32'(row_sel_o), 32'(row));
      chk({tag, ".dart"}, 32'(dart_come_o), 32'(dc));
      chk({tag, ".busy"}, 32'(busy_o), 32'(bz));
      chk({tag, ".err"}, 32'(error_o), 32'(er));
   endtask

   task automatic chk_xy(input string tag, input logic [3:0] x,
                         input logic [3:0] y);
      chk({tag, ".x"}, 32'(dart_position_x_o), 32'(x));
      chk({tag, ".y"}, 32'(dart_position_y_o), 32'(y));
   endtask

   task automatic wait_row(input string tag, input logic [9:0] target);
      for (int i = 0; i < 20; i++) begin
         if (row_sel_o === target) break;
         step();
      end
      chk(tag, 32'(row_sel_o), 32'(target));
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b0;
      col_sense_i = 10'd0;
      turn_done_i = 1'b0;
      game_set_i  = 1'b0;
      step();
      step();
      chk_out("reset", 10'h001, 1'b0, 1'b0, 1'b0);
      chk_xy("reset", 4'd0, 4'd0);
      reset = 1'b1;

      // idle walk: row index steps 0..9 and wraps
      for (int i = 1; i <= 25; i++) begin
         step();
         chk_out("walk", 10'd1 << (i % 10), 1'b0, 1'b0, 1'b0);
      end

      // steady hit at row 3, column 6
      wait_row("seek_r3", 10'h008);
      col_sense_i = 10'd1 << 6;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("confirm_r3", 10'h008, 1'b0, 1'b0, 1'b0);
      end
      step();
      chk_out("emit_r3", 10'h000, 1'b1, 1'b1, 1'b0);
      chk_xy("emit_r3", 4'd6, 4'd3);
      step();
      chk_out("ack_r3", 10'h000, 1'b0, 1'b1, 1'b0);
      step();
      chk_out("ack_hold", 10'h000, 1'b0, 1'b1, 1'b0);

      // turn done while contact still present
      turn_done_i = 1'b1;
      step();
      turn_done_i = 1'b0;
      chk_out("clear_enter", 10'h3FF, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("clear_busy", 10'h3FF, 1'b0, 1'b1, 1'b0);
      end
      col_sense_i = 10'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("clear_cnt", 10'h3FF, 1'b0, 1'b1, 1'b0);
      end
      step();
      chk_out("clear_done", 10'h001, 1'b0, 1'b0, 1'b0);
      chk_xy("clear_done", 4'd6, 4'd3);

      // second hit at x=0, y=9
      wait_row("seek_r9", 10'h200);
      col_sense_i = 10'h001;
      for (int i = 0; i < 3; i++) step();
      chk_out("confirm_r9", 10'h200, 1'b0, 1'b0, 1'b0);
      step();
      chk_out("emit_r9", 10'h000, 1'b1, 1'b1, 1'b0);
      chk_xy("emit_r9", 4'd0, 4'd9);
      col_sense_i = 10'd0;
      step();
      turn_done_i = 1'b1;
      step();
      turn_done_i = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk_out("rescan", 10'h001, 1'b0, 1'b0, 1'b0);

      // bounce at row 5, column 2 after two samples
      wait_row("seek_r5", 10'h020);
      col_sense_i = 10'd1 << 2;
      step();
      step();
      chk_out("bounce_hold", 10'h020, 1'b0, 1'b0, 1'b0);
      col_sense_i = 10'd0;
      step();
      chk_out("bounce_drop", 10'h040, 1'b0, 1'b0, 1'b0);
      chk_xy("bounce_drop", 4'd0, 4'd9);

      // two columns on row 2
      wait_row("seek_r2", 10'h004);
      col_sense_i = 10'h012;
      step();
      col_sense_i = 10'd0;
      chk_out("multi", 10'h008, 1'b0, 1'b0, 1'b1);
      step();
      chk_out("multi_after", 10'h010, 1'b0, 1'b0, 1'b0);

      // hit at row 4, column 7, then game set together with turn done
      col_sense_i = 10'd1 << 7;
      for (int i = 0; i < 3; i++) step();
      step();
      chk_out("emit_r4", 10'h000, 1'b1, 1'b1, 1'b0);
      chk_xy("emit_r4", 4'd7, 4'd4);
      col_sense_i = 10'd0;
      step();
      turn_done_i = 1'b1;
      game_set_i  = 1'b1;
      step();
      turn_done_i = 1'b0;
      game_set_i  = 1'b0;
      chk_out("halt", 10'h000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         col_sense_i = (i % 2 == 0) ? 10'd1 << (i % 10) : 10'd0;
         turn_done_i = (i % 3 == 0);
         step();
         chk_out("halt_hold", 10'h000, 1'b0, 1'b1, 1'b0);
      end
      chk_xy("halt_hold", 4'd7, 4'd4);
      col_sense_i = 10'd0;
      turn_done_i = 1'b0;

      reset = 1'b0;
      step();
      chk_out("halt_reset", 10'h001, 1'b0, 1'b0, 1'b0);
      chk_xy("halt_reset", 4'd0, 4'd0);
      reset = 1'b1;
      step();
      chk_out("post_reset", 10'h002, 1'b0, 1'b0, 1'b0);

      // game set straight from SCAN
      game_set_i = 1'b1;
      step();
      game_set_i = 1'b0;
      chk_out("scan_halt", 10'h000, 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
